// File: rtl/riscv_instr_line_server.sv
// Instruction-line responder: serves 128-bit line fetches by issuing four 32-bit word reads.
// A one-entry line register answers repeat fetches of the same line without touching memory.
module riscv_instr_line_server #(
    parameter int RDATA_OUT_WIDTH = 128
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  instr_req_i,
    input  logic [31:0]                           instr_addr_i,
    output logic                                  instr_gnt_o,
    output logic                                  instr_rvalid_o,
    output logic [RDATA_OUT_WIDTH/32-1:0][31:0]   instr_rdata_o,
    input  logic                                  flush_i,
    output logic                                  mem_req_o,
    output logic [31:0]                           mem_addr_o,
    input  logic                                  mem_gnt_i,
    input  logic                                  mem_rvalid_i,
    input  logic [31:0]                           mem_rdata_i,
    output logic                                  busy_o
);

    localparam int WORDS = RDATA_OUT_WIDTH / 32;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, RETURN} state_t;

    state_t                   state_q, state_d;
    logic [27:0]              tag_q;
    logic                     line_valid_q;
    logic                     flush_seen_q;
    logic [2:0]               issue_cnt_q;
    logic [2:0]               ret_cnt_q;
    logic [WORDS-1:0][31:0]   line_q;

    logic gnt, hit, miss_gnt, beat_gnt, word_cap, last_issue, last_word, fetching;

    // The line offset bits never influence the line that is served.
    logic unused_offset;
    assign unused_offset = ^instr_addr_i[3:0];

    assign fetching   = (state_q == FETCH) || (state_q == DRAIN);
    assign gnt        = !rst && instr_req_i && ((state_q == IDLE) || (state_q == RETURN));
    assign hit        = line_valid_q && !flush_i && (instr_addr_i[31:4] == tag_q);
    assign miss_gnt   = gnt && !hit;
    assign beat_gnt   = (state_q == FETCH) && mem_gnt_i && (issue_cnt_q < 3'd4);
    assign word_cap   = fetching && mem_rvalid_i && (ret_cnt_q < 3'd4);
    assign last_issue = beat_gnt && (issue_cnt_q == 3'd3);
    assign last_word  = word_cap && (ret_cnt_q == 3'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the line register is reset too, so instr_rdata_o reads 0 until the first fill.
            state_q      <= IDLE;
            tag_q        <= '0;
            line_valid_q <= 1'b0;
            flush_seen_q <= 1'b0;
            issue_cnt_q  <= '0;
            ret_cnt_q    <= '0;
            line_q       <= '0;
        end else begin
            state_q <= state_d;
            if (miss_gnt) begin
                tag_q        <= instr_addr_i[31:4];
                issue_cnt_q  <= '0;
                ret_cnt_q    <= '0;
                flush_seen_q <= 1'b0;
            end else begin
                if (beat_gnt) issue_cnt_q <= issue_cnt_q + 3'd1;
                if (word_cap) begin
                    line_q[ret_cnt_q[1:0]] <= mem_rdata_i;
                    ret_cnt_q              <= ret_cnt_q + 3'd1;
                end
                if (flush_i && fetching) flush_seen_q <= 1'b1;
            end
            // A flush or a new tag always wins over validating the returned line.
            if (flush_i || miss_gnt)
                line_valid_q <= 1'b0;
            else if ((state_q == RETURN) && !flush_seen_q)
                line_valid_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, RETURN: begin
                if (gnt) state_d = hit ? RETURN : FETCH;
                else     state_d = IDLE;
            end
            FETCH:   if (last_issue) state_d = last_word ? RETURN : DRAIN;
            DRAIN:   if (last_word)  state_d = RETURN;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: outputs are gated with rst so they read 0 in the reset cycle itself, not one cycle later.
    always_comb begin
        instr_gnt_o    = gnt;
        instr_rvalid_o = !rst && (state_q == RETURN);
        instr_rdata_o  = rst ? '0 : line_q;
        mem_req_o      = !rst && (state_q == FETCH);
        mem_addr_o     = mem_req_o ? {tag_q, issue_cnt_q[1:0], 2'b00} : 32'h0;
        busy_o         = !rst && (state_q != IDLE);
    end

endmodule

// File: tb/tb_riscv_instr_line_server.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level model
// of the line server and an in-order, variable-latency word memory.
module tb_riscv_instr_line_server;

    logic              clk;
    logic              rst;
    logic              instr_req_i;
    logic [31:0]       instr_addr_i;
    logic              instr_gnt_o;
    logic              instr_rvalid_o;
    logic [3:0][31:0]  instr_rdata_o;
    logic              flush_i;
    logic              mem_req_o;
    logic [31:0]       mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [31:0]       mem_rdata_i;
    logic              busy_o;

    riscv_instr_line_server #(.RDATA_OUT_WIDTH(128)) dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000123) return 32'hA0 + 32'(a[3:2]);
        return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
    endfunction

    function automatic logic [127:0] line_of(input logic [27:0] tag);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[32*i +: 32] = mem_word({tag, 2'(i), 2'b00});
        return l;
    endfunction

    // Memory environment: in-order word returns, each at least one cycle after its grant.
    typedef struct { logic [31:0] addr; int ready; } beat_t;
    beat_t q[$];
    int    last_ready = -1;
    int    gnt_pct    = 100;
    int    lat_max    = 1;
    int    stall_left = 0;
    int    beats_total = 0;

    // Transaction-level model state.
    int          cyc = 0;
    bit          busy_m, is_miss, valid_m, flush_during;
    int          gnt_cyc, due_cyc, beats_m, words_m;
    logic [27:0] line_tag_m;
    bit          gnt_seen, rv_seen;
    int          g_cyc, rv_cyc;

    task automatic model_reset();
        busy_m = 0; is_miss = 0; valid_m = 0; flush_during = 0;
        gnt_cyc = 0; due_cyc = -1; beats_m = 0; words_m = 0; line_tag_m = '0;
        q.delete(); last_ready = -1; stall_left = 0;
    endtask

    task automatic cycle(input logic r, input logic [31:0] a, input logic f, input logic rs);
        bit got_word, exp_rv, exp_gnt, exp_mreq, exp_busy, hit;
        @(negedge clk);
        rst = rs; instr_req_i = r; instr_addr_i = a; flush_i = f;
        got_word = 0;
        if (rs) mem_gnt_i = 1'b0;
        else if (stall_left > 0 && busy_m && is_miss && cyc > gnt_cyc && beats_m == 2) begin
            mem_gnt_i = 1'b0;
            stall_left--;
        end else mem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
        if (!rs && q.size() > 0 && q[0].ready <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(q[0].addr);
            void'(q.pop_front());
            got_word = 1;
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
        end
        #1;
        if (rs) begin
            check("rst_ctrl", {instr_gnt_o, instr_rvalid_o, mem_req_o, busy_o, mem_addr_o}, '0);
            check("rst_rdata", instr_rdata_o, '0);
            model_reset();
        end else begin
            exp_rv   = busy_m && (due_cyc == cyc);
            exp_gnt  = r && (!busy_m || exp_rv);
            exp_mreq = busy_m && is_miss && (cyc > gnt_cyc) && (beats_m < 4);
            exp_busy = busy_m && (cyc > gnt_cyc);
            hit      = valid_m && !f && (a[31:4] == line_tag_m);
            check("gnt", instr_gnt_o, exp_gnt);
            check("rvalid", instr_rvalid_o, exp_rv);
            check("mem_req", mem_req_o, exp_mreq);
            check("busy", busy_o, exp_busy);
            if (exp_mreq) check("mem_addr", mem_addr_o, {line_tag_m, 2'(beats_m), 2'b00});
            if (exp_rv)   check("rdata", instr_rdata_o, line_of(line_tag_m));

            if (exp_mreq && mem_gnt_i) begin
                int lat = $urandom_range(1, lat_max);
                int rdy = cyc + lat;
                if (rdy <= last_ready) rdy = last_ready + 1;
                last_ready = rdy;
                q.push_back('{addr: {line_tag_m, 2'(beats_m), 2'b00}, ready: rdy});
                beats_m++;
                beats_total++;
            end
            if (got_word) begin
                words_m++;
                if (words_m == 4) due_cyc = cyc + 1;
            end
            if (f) begin
                valid_m = 0;
                if (busy_m && is_miss && !exp_rv) flush_during = 1;
            end
            if (exp_rv) begin
                if (!f && !flush_during) valid_m = 1;
                busy_m = 0;
                rv_seen = 1;
                rv_cyc = cyc;
            end
            if (exp_gnt) begin
                busy_m = 1; gnt_cyc = cyc; beats_m = 0; words_m = 0; flush_during = 0;
                is_miss = !hit;
                due_cyc = hit ? cyc + 1 : -1;
                if (!hit) begin
                    line_tag_m = a[31:4];
                    valid_m = 0;
                end
                gnt_seen = 1; rv_seen = 0; g_cyc = cyc;
            end
        end
        cyc++;
    endtask

    task automatic request(input logic [31:0] a);
        int n = 0;
        gnt_seen = 0;
        while (!gnt_seen && n < 50) begin
            cycle(1'b1, a, 1'b0, 1'b0);
            n++;
        end
        if (!gnt_seen) check("gnt_timeout", gnt_seen, 1'b1);
    endtask

    task automatic wait_rv();
        int n = 0;
        while (!rv_seen && n < 100) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            n++;
        end
        check("rv_done", rv_seen, 1'b1);
    endtask

    logic [31:0] lines [4] = '{32'h1230, 32'h1240, 32'h2000, 32'h3000};

    initial begin
        int b0, n;
        rst = 1'b1; instr_req_i = 1'b0; instr_addr_i = '0; flush_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        model_reset();

        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 32'h1234, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("idle_rdata", instr_rdata_o, '0);

        // Cold miss with 1-cycle memory.
        gnt_pct = 100; lat_max = 1;
        b0 = beats_total;
        request(32'h1234);
        wait_rv();
        check("miss_lat", 32'(rv_cyc - g_cyc), 32'd6);
        check("miss_beats", 32'(beats_total - b0), 32'd4);
        check("miss_data", instr_rdata_o, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Repeat fetch hits.
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        b0 = beats_total;
        request(32'h123C);
        wait_rv();
        check("hit_lat", 32'(rv_cyc - g_cyc), 32'd1);
        check("hit_beats", 32'(beats_total - b0), 32'd0);

        // Hit, repeat hit in the RETURN cycle, then a miss granted in the next RETURN cycle.
        cycle(1'b1, 32'h1230, 1'b0, 1'b0);
        cycle(1'b1, 32'h1238, 1'b0, 1'b0);
        check("b2b_hit", 32'(g_cyc), 32'(rv_cyc));
        cycle(1'b1, 32'h1240, 1'b0, 1'b0);
        check("b2b_miss", 32'(g_cyc), 32'(rv_cyc));
        wait_rv();

        // Beat 2 grant stalled 3 cycles with variable return latency.
        stall_left = 3; lat_max = 4;
        b0 = beats_total;
        request(32'h2008);
        wait_rv();
        check("stall_beats", 32'(beats_total - b0), 32'd4);

        // Flush during DRAIN: line still returned, next request refetches.
        lat_max = 4;
        request(32'h3000);
        n = 0;
        while (!(beats_m == 4 && words_m < 4) && n < 50) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            n++;
        end
        check("drain_reached", busy_o, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        wait_rv();
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        b0 = beats_total;
        request(32'h3004);
        wait_rv();
        check("flush_refetch", 32'(beats_total - b0), 32'd4);

        // Reset after two beats of a fetch.
        lat_max = 3;
        request(32'h4000);
        n = 0;
        while (beats_m < 2 && n < 50) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            n++;
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("post_rst_rdata", instr_rdata_o, '0);
        b0 = beats_total;
        request(32'h3000);
        wait_rv();
        check("post_rst_miss", 32'(beats_total - b0), 32'd4);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] a;
            if (i % 200 == 0) begin
                gnt_pct = $urandom_range(30, 100);
                lat_max = $urandom_range(1, 4);
            end
            a = lines[$urandom_range(0, 3)] + $urandom_range(0, 15);
            cycle($urandom_range(0, 99) < 70, a, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 999) < 3);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
